crtc_regs: RTL and testbench
============================

CRTC_REGS -- requirements
Module: crtc_regs

Interface
REQ-001 Parameter APPLY_AT_VSYNC, default 1: 1 = shadow-to-active transfer only at v_sync rising edge; 0 = transfer on every clock.
REQ-002 clk16_i  in  1  system clock; all logic on its rising edge.
REQ-003 reset_n_i  in  1  asynchronous, active-low reset.
REQ-004 crtc_select_i  in  1  CRTC chip select, decoded from the CPU bus.
REQ-005 cpu_strobe_i  in  1  one-cycle access qualifier, high for exactly one clk16 cycle per CPU bus cycle.
REQ-006 rw_n_i  in  1  1 = read, 0 = write.
REQ-007 rs_i  in  1  register select: 0 = address register, 1 = data register.
REQ-008 data_i  in  8  CPU write data.
REQ-009 data_o  out  8  CPU read data.
REQ-010 v_sync_i  in  1  vertical sync from video_gen, already in the clk16 domain.
REQ-011 h_char_total_o 8, h_char_displayed_o 8, h_sync_start_o 8, h_sync_width_o 4  out  horizontal timing to video_gen.
REQ-012 v_char_total_o 7, v_adjust_o 5, v_char_displayed_o 7, v_sync_start_o 7, v_sync_width_o 4, v_char_height_o 5  out  vertical timing to video_gen.
REQ-013 start_addr_o  out  14  display start address.
REQ-014 pending_o  out  1  set when the shadow registers hold uncommitted writes.
REQ-015 commit_o  out  1  one-cycle pulse when shadow is copied to active.

Function
REQ-016 Write strobe = crtc_select_i & cpu_strobe_i & ~rw_n_i; all writes occur only on that clock edge.
REQ-017 Write with rs_i=0 SHALL load the 5-bit address register from data_i[4:0].
REQ-018 Write with rs_i=1 SHALL load the shadow register selected by the address register and set pending.
REQ-019 Register map and shadow widths:
- R0 h_char_total [7:0]; R1 h_char_displayed [7:0]; R2 h_sync_start [7:0].
- R3: [3:0] h_sync_width, [7:4] v_sync_width.
- R4 v_char_total [6:0]; R5 v_adjust [4:0]; R6 v_char_displayed [6:0]; R7 v_sync_start [6:0].
- R9 v_char_height [4:0].
- R12 start_addr[13:8] (data_i[5:0]); R13 start_addr[7:0].
- Upper data bits beyond each register's width are discarded.
REQ-020 Writes to R8, R10, R11 and R14-R31 SHALL be ignored and SHALL NOT set pending.
REQ-021 data_o is combinational.
- rs_i=1: the selected shadow value, zero-extended; unimplemented registers read 8'h00.
- rs_i=0: {pending, 7'b0}.
REQ-022 Reads SHALL have no side effects.
REQ-023 Vsync edge: v_sync_i is registered into v_sync_q; edge = v_sync_i & ~v_sync_q.
REQ-024 With APPLY_AT_VSYNC=1, the edge SHALL trigger the following on the same clock edge:
- all active registers load from shadow;
- pending clears;
- commit_o is high for the next cycle.
- Outputs therefore change one clk16 cycle after v_sync_i is first sampled high.
REQ-025 Edge coincident with a data write:
- active takes the pre-write shadow;
- shadow takes the new value;
- pending remains set.
REQ-026 With APPLY_AT_VSYNC=0, active SHALL equal shadow one cycle after each write, and pending_o/commit_o SHALL stay 0.
REQ-027 An edge with pending clear SHALL NOT pulse commit_o; active is unchanged.
REQ-028 All timing outputs SHALL be driven directly from active registers, with no combinational arithmetic.

Reset
REQ-029 Asserting reset_n_i low SHALL immediately load shadow and active from the package reset values:
- R0=63, R1=40, R2=48, R3=8'h1F, R4=31, R5=0, R6=25, R7=28, R9=7, start=0.
REQ-030 Reset SHALL also clear: address register=0, pending=0, commit_o=0, v_sync_q=0.
REQ-031 Reset asserted mid-frame or mid-write SHALL discard all uncommitted writes; no commit occurs until the first vsync edge after release.

Structure
REQ-032 Package crtc_pkg SHALL hold:
- register index localparams R0-R13;
- reset-value constants;
- a typedef for the timing bundle (one field per timing output).
REQ-033 No sub-module is required; edge detection and the register file are local to crtc_regs.

Verification
REQ-034 After reset: outputs = reset values; data_o with rs=1, addr=1 reads 8'h28; pending_o=0.
REQ-035 Write addr=0, data=8'd79 → h_char_total_o stays 63 and pending_o=1 until the v_sync_i rise; then 79 one cycle later, with a single commit_o pulse and pending_o=0.
REQ-036 Write R3=8'hA5 → after commit: h_sync_width_o=5, v_sync_width_o=10. Write R12=8'hFF → start_addr_o[13:8]=6'h3F.
REQ-037 Write R1=8'd20 on the same clock as the v_sync edge → h_char_displayed_o unchanged at this vsync, pending_o stays 1, value becomes 20 at the next vsync.
REQ-038 Write addr=15, data=8'h55 → pending_o stays 0, readback 8'h00, no commit_o at the next vsync.
REQ-039 Write R0=8'd10, then pulse reset_n_i low before vsync → h_char_total_o=63, pending_o=0; no commit at the next vsync.

Source files
------------

// File: rtl/crtc_pkg.sv
// Shared definitions for the CRTC register file: register indices,
// reset values and the timing bundle handed to video_gen.
package crtc_pkg;

    localparam logic [4:0] R0  = 5'd0;
    localparam logic [4:0] R1  = 5'd1;
    localparam logic [4:0] R2  = 5'd2;
    localparam logic [4:0] R3  = 5'd3;
    localparam logic [4:0] R4  = 5'd4;
    localparam logic [4:0] R5  = 5'd5;
    localparam logic [4:0] R6  = 5'd6;
    localparam logic [4:0] R7  = 5'd7;
    localparam logic [4:0] R8  = 5'd8;
    localparam logic [4:0] R9  = 5'd9;
    localparam logic [4:0] R10 = 5'd10;
    localparam logic [4:0] R11 = 5'd11;
    localparam logic [4:0] R12 = 5'd12;
    localparam logic [4:0] R13 = 5'd13;

    localparam logic [7:0]  RST_H_CHAR_TOTAL     = 8'd63;
    localparam logic [7:0]  RST_H_CHAR_DISPLAYED = 8'd40;
    localparam logic [7:0]  RST_H_SYNC_START     = 8'd48;
    localparam logic [3:0]  RST_H_SYNC_WIDTH     = 4'hF;
    localparam logic [6:0]  RST_V_CHAR_TOTAL     = 7'd31;
    localparam logic [4:0]  RST_V_ADJUST         = 5'd0;
    localparam logic [6:0]  RST_V_CHAR_DISPLAYED = 7'd25;
    localparam logic [6:0]  RST_V_SYNC_START     = 7'd28;
    localparam logic [3:0]  RST_V_SYNC_WIDTH     = 4'h1;
    localparam logic [4:0]  RST_V_CHAR_HEIGHT    = 5'd7;
    localparam logic [13:0] RST_START_ADDR       = 14'd0;

    typedef struct packed {
        logic [7:0]  h_char_total;
        logic [7:0]  h_char_displayed;
        logic [7:0]  h_sync_start;
        logic [3:0]  h_sync_width;
        logic [6:0]  v_char_total;
        logic [4:0]  v_adjust;
        logic [6:0]  v_char_displayed;
        logic [6:0]  v_sync_start;
        logic [3:0]  v_sync_width;
        logic [4:0]  v_char_height;
        logic [13:0] start_addr;
    } timing_t;

    localparam timing_t TIMING_RST = '{
        h_char_total:     RST_H_CHAR_TOTAL,
        h_char_displayed: RST_H_CHAR_DISPLAYED,
        h_sync_start:     RST_H_SYNC_START,
        h_sync_width:     RST_H_SYNC_WIDTH,
        v_char_total:     RST_V_CHAR_TOTAL,
        v_adjust:         RST_V_ADJUST,
        v_char_displayed: RST_V_CHAR_DISPLAYED,
        v_sync_start:     RST_V_SYNC_START,
        v_sync_width:     RST_V_SYNC_WIDTH,
        v_char_height:    RST_V_CHAR_HEIGHT,
        start_addr:       RST_START_ADDR
    };

endpackage

// File: rtl/crtc_regs.sv
// CRTC register file: CPU-written shadow registers, committed to the active
// timing set on v_sync rising edge (or every clock when APPLY_AT_VSYNC=0).
module crtc_regs
    import crtc_pkg::*;
#(
    parameter bit APPLY_AT_VSYNC = 1'b1
) (
    input  logic        clk16_i,
    input  logic        reset_n_i,
    input  logic        crtc_select_i,
    input  logic        cpu_strobe_i,
    input  logic        rw_n_i,
    input  logic        rs_i,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    input  logic        v_sync_i,
    output logic [7:0]  h_char_total_o,
    output logic [7:0]  h_char_displayed_o,
    output logic [7:0]  h_sync_start_o,
    output logic [3:0]  h_sync_width_o,
    output logic [6:0]  v_char_total_o,
    output logic [4:0]  v_adjust_o,
    output logic [6:0]  v_char_displayed_o,
    output logic [6:0]  v_sync_start_o,
    output logic [3:0]  v_sync_width_o,
    output logic [4:0]  v_char_height_o,
    output logic [13:0] start_addr_o,
    output logic        pending_o,
    output logic        commit_o
);

    timing_t    shadow;
    timing_t    shadow_nxt;
    timing_t    active;
    logic [4:0] addr;
    logic       pending;
    logic       commit;
    logic       v_sync_q;
    logic       wr_en;
    logic       data_wr;
    logic       hit;
    logic       vs_edge;

    assign wr_en   = crtc_select_i & cpu_strobe_i & ~rw_n_i;
    assign data_wr = wr_en & rs_i;
    assign vs_edge = v_sync_i & ~v_sync_q;

    always_comb begin
        shadow_nxt = shadow;
        hit        = 1'b0;
        if (data_wr) begin
            hit = 1'b1;
            case (addr)
                R0:  shadow_nxt.h_char_total     = data_i;
                R1:  shadow_nxt.h_char_displayed = data_i;
                R2:  shadow_nxt.h_sync_start     = data_i;
                R3: begin
                    shadow_nxt.h_sync_width = data_i[3:0];
                    shadow_nxt.v_sync_width = data_i[7:4];
                end
                R4:  shadow_nxt.v_char_total      = data_i[6:0];
                R5:  shadow_nxt.v_adjust          = data_i[4:0];
                R6:  shadow_nxt.v_char_displayed  = data_i[6:0];
                R7:  shadow_nxt.v_sync_start      = data_i[6:0];
                R9:  shadow_nxt.v_char_height     = data_i[4:0];
                R12: shadow_nxt.start_addr[13:8]  = data_i[5:0];
                R13: shadow_nxt.start_addr[7:0]   = data_i;
                default: hit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk16_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shadow   <= TIMING_RST;
            active   <= TIMING_RST;
            addr     <= '0;
            pending  <= 1'b0;
            commit   <= 1'b0;
            v_sync_q <= 1'b0;
        end else begin
            v_sync_q <= v_sync_i;
            shadow   <= shadow_nxt;
            if (wr_en && !rs_i)
                addr <= data_i[4:0];
            if (APPLY_AT_VSYNC) begin
                // active takes the pre-write shadow; a coincident write keeps pending set
                commit  <= vs_edge & pending;
                pending <= (pending & ~vs_edge) | hit;
                if (vs_edge && pending)
                    active <= shadow;
            end else begin
                commit  <= 1'b0;
                pending <= 1'b0;
                active  <= shadow;
            end
        end
    end

    always_comb begin
        data_o = {pending, 7'b0};
        if (rs_i) begin
            case (addr)
                R0:      data_o = shadow.h_char_total;
                R1:      data_o = shadow.h_char_displayed;
                R2:      data_o = shadow.h_sync_start;
                R3:      data_o = {shadow.v_sync_width, shadow.h_sync_width};
                R4:      data_o = {1'b0, shadow.v_char_total};
                R5:      data_o = {3'b0, shadow.v_adjust};
                R6:      data_o = {1'b0, shadow.v_char_displayed};
                R7:      data_o = {1'b0, shadow.v_sync_start};
                R9:      data_o = {3'b0, shadow.v_char_height};
                R12:     data_o = {2'b0, shadow.start_addr[13:8]};
                R13:     data_o = shadow.start_addr[7:0];
                default: data_o = 8'h00;
            endcase
        end
    end

    assign h_char_total_o     = active.h_char_total;
    assign h_char_displayed_o = active.h_char_displayed;
    assign h_sync_start_o     = active.h_sync_start;
    assign h_sync_width_o     = active.h_sync_width;
    assign v_char_total_o     = active.v_char_total;
    assign v_adjust_o         = active.v_adjust;
    assign v_char_displayed_o = active.v_char_displayed;
    assign v_sync_start_o     = active.v_sync_start;
    assign v_sync_width_o     = active.v_sync_width;
    assign v_char_height_o    = active.v_char_height;
    assign start_addr_o       = active.start_addr;
    assign pending_o          = pending;
    assign commit_o           = commit;

endmodule

// File: tb/tb_crtc_regs.sv
// Scoreboard bench for crtc_regs: a byte-array register model predicts reads
// and commits; a monitor process compares on every commit_o and read cycle.
module tb_crtc_regs;

    logic        clk16_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        crtc_select_i = 1'b0;
    logic        cpu_strobe_i = 1'b0;
    logic        rw_n_i = 1'b1;
    logic        rs_i = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic [7:0]  data_o;
    logic        v_sync_i = 1'b0;
    logic [7:0]  h_char_total_o, h_char_displayed_o, h_sync_start_o;
    logic [3:0]  h_sync_width_o, v_sync_width_o;
    logic [6:0]  v_char_total_o, v_char_displayed_o, v_sync_start_o;
    logic [4:0]  v_adjust_o, v_char_height_o;
    logic [13:0] start_addr_o;
    logic        pending_o, commit_o;

    crtc_regs #(.APPLY_AT_VSYNC(1'b1)) dut (
        .clk16_i(clk16_i), .reset_n_i(reset_n_i), .crtc_select_i(crtc_select_i),
        .cpu_strobe_i(cpu_strobe_i), .rw_n_i(rw_n_i), .rs_i(rs_i), .data_i(data_i),
        .data_o(data_o), .v_sync_i(v_sync_i),
        .h_char_total_o(h_char_total_o), .h_char_displayed_o(h_char_displayed_o),
        .h_sync_start_o(h_sync_start_o), .h_sync_width_o(h_sync_width_o),
        .v_char_total_o(v_char_total_o), .v_adjust_o(v_adjust_o),
        .v_char_displayed_o(v_char_displayed_o), .v_sync_start_o(v_sync_start_o),
        .v_sync_width_o(v_sync_width_o), .v_char_height_o(v_char_height_o),
        .start_addr_o(start_addr_o), .pending_o(pending_o), .commit_o(commit_o)
    );

    always #5 clk16_i = ~clk16_i;

    typedef struct {
        logic [7:0]  data;
        logic        pend;
        logic [76:0] act;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [76:0] cm_q[$];

    // Register model: one byte per register index, masked to its width
    logic [7:0] sh_m[32];
    logic [7:0] ac_m[32];
    logic       pend_m, vsq_m;
    logic [4:0] addr_m;
    logic       rd_chk = 1'b0;
    logic       done = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    logic [76:0] dut_act;
    assign dut_act = {h_char_total_o, h_char_displayed_o, h_sync_start_o, h_sync_width_o,
                      v_char_total_o, v_adjust_o, v_char_displayed_o, v_sync_start_o,
                      v_sync_width_o, v_char_height_o, start_addr_o};

    function automatic logic [7:0] reg_mask(input logic [4:0] r);
        case (r)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd13: return 8'hFF;
            5'd4, 5'd6, 5'd7:              return 8'h7F;
            5'd5, 5'd9:                    return 8'h1F;
            5'd12:                         return 8'h3F;
            default:                       return 8'h00;
        endcase
    endfunction

    function automatic logic [76:0] pack_active();
        return {ac_m[0], ac_m[1], ac_m[2], ac_m[3][3:0], ac_m[4][6:0], ac_m[5][4:0],
                ac_m[6][6:0], ac_m[7][6:0], ac_m[3][7:4], ac_m[9][4:0],
                ac_m[12][5:0], ac_m[13]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) sh_m[i] = 8'h00;
        sh_m[0] = 8'd63; sh_m[1] = 8'd40; sh_m[2] = 8'd48; sh_m[3] = 8'h1F;
        sh_m[4] = 8'd31; sh_m[5] = 8'd0;  sh_m[6] = 8'd25; sh_m[7] = 8'd28;
        sh_m[9] = 8'd7;
        ac_m   = sh_m;
        pend_m = 1'b0;
        vsq_m  = 1'b0;
        addr_m = 5'd0;
    endtask

    // Called at posedge+1: drive one bus cycle, then advance the model at the next edge
    task automatic cycle(input logic wr, input logic rd, input logic rs,
                         input logic [7:0] d, input logic vs);
        rd_exp_t e;
        logic    edge_m;
        crtc_select_i = wr | rd;
        cpu_strobe_i  = wr | rd;
        rw_n_i        = ~wr;
        rs_i          = rs;
        data_i        = d;
        v_sync_i      = vs;
        rd_chk        = rd;
        if (rd) begin
            e.data = rs ? sh_m[addr_m] : {pend_m, 7'b0};
            e.pend = pend_m;
            e.act  = pack_active();
            rd_q.push_back(e);
        end
        @(posedge clk16_i);
        edge_m = vs & ~vsq_m;
        vsq_m  = vs;
        if (edge_m && pend_m) begin
            ac_m = sh_m;
            cm_q.push_back(pack_active());
        end
        if (edge_m) pend_m = 1'b0;
        if (wr) begin
            if (!rs) addr_m = d[4:0];
            else if (reg_mask(addr_m) != 8'h00) begin
                sh_m[addr_m] = d & reg_mask(addr_m);
                pend_m = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n_i     = 1'b0;
        crtc_select_i = 1'b0;
        cpu_strobe_i  = 1'b0;
        rw_n_i        = 1'b1;
        v_sync_i      = 1'b0;
        rd_chk        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk16_i);
        #1;
        reset_n_i = 1'b1;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [7:0] d);
        cycle(1'b1, 1'b0, 1'b0, {3'b0, a}, v_sync_i);
        cycle(1'b1, 1'b0, 1'b1, d, v_sync_i);
    endtask

    task automatic vsync_pulse();
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic rd_both();
        cycle(1'b0, 1'b1, 1'b0, 8'h00, v_sync_i);
        cycle(1'b0, 1'b1, 1'b1, 8'h00, v_sync_i);
    endtask

    // Stimulus
    initial begin
        logic vs_r;
        int   r;
        logic [7:0] d;
        model_reset();
        repeat (2) @(posedge clk16_i);
        #1;
        reset_n_i = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);

        wr_reg(5'd0, 8'd79);
        rd_both();
        vsync_pulse();
        rd_both();

        wr_reg(5'd3, 8'hA5);
        wr_reg(5'd12, 8'hFF);
        vsync_pulse();
        rd_both();

        wr_reg(5'd2, 8'd50);
        cycle(1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'd20, 1'b1);
        rd_both();
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        vsync_pulse();
        rd_both();

        wr_reg(5'd15, 8'h55);
        rd_both();
        vsync_pulse();

        wr_reg(5'd0, 8'd10);
        do_reset();
        rd_both();
        vsync_pulse();
        rd_both();

        vs_r = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            if ($urandom_range(0, 7) == 0) vs_r = ~vs_r;
            r = $urandom_range(0, 9);
            d = 8'($urandom);
            if (r < 2)      cycle(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 15)), vs_r);
            else if (r < 3) cycle(1'b1, 1'b0, 1'b0, d, vs_r);
            else if (r < 5) cycle(1'b1, 1'b0, 1'b1, d, vs_r);
            else if (r < 8) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'h00, vs_r);
            else            cycle(1'b0, 1'b0, 1'b0, 8'h00, vs_r);
        end
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        done = 1'b1;
    end

    task automatic check(input string name, input logic [76:0] act, input logic [76:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        rd_exp_t     e;
        logic [76:0] c;
        forever begin
            @(negedge clk16_i);
            check("commit_o", {76'b0, commit_o}, {76'b0, (cm_q.size() != 0)});
            if (commit_o && cm_q.size() != 0) begin
                c = cm_q.pop_front();
                check("commit_timing", dut_act, c);
            end else if (cm_q.size() != 0) begin
                void'(cm_q.pop_front());
            end
            if (rd_chk) begin
                if (rd_q.size() == 0) begin
                    check("read_queue_empty", 77'd1, 77'd0);
                end else begin
                    e = rd_q.pop_front();
                    check("data_o", {69'b0, data_o}, {69'b0, e.data});
                    check("pending_o", {76'b0, pending_o}, {76'b0, e.pend});
                    check("active_timing", dut_act, e.act);
                end
            end
            if (done) break;
        end
        check("leftover_expectations", 77'(cm_q.size() + rd_q.size()), 77'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required done");
        $fatal(1);
    end

endmodule
